// File: rtl/pmbist_resp_checker.sv
// PMBIST read-side response analyser: delays expected data/address by the memory
// read latency, compares with mem_q and keeps sticky pass/fail and first-failure info.
module pmbist_resp_checker #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cmp_en,
  input  logic [DW-1:0]    exp_data,
  input  logic [AW-1:0]    rd_addr,
  input  logic [DW-1:0]    mem_q,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             err_pulse,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [AW-1:0]    first_addr,
  output logic [DW-1:0]    first_exp,
  output logic [DW-1:0]    first_got
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [READ_LAT-1:0] LAST_BIT = READ_LAT'(1) << (READ_LAT - 1);

  state_t               state_r, state_nxt_s;
  logic [READ_LAT-1:0]  vld_r;
  logic [DW-1:0]        exp_r  [READ_LAT];
  logic [AW-1:0]        addr_r [READ_LAT];
  logic                 pending_s, cmp_live_s, mismatch_s;

  logic                 busy_r, done_r, fail_r, err_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [AW-1:0]        first_addr_r;
  logic [DW-1:0]        first_exp_r, first_got_r;

  // The last stage is compared on this edge, so only the earlier stages keep DRAIN alive.
  assign pending_s  = |(vld_r & ~LAST_BIT);
  assign cmp_live_s = vld_r[READ_LAT-1] && ((state_r == RUN) || (state_r == DRAIN)) && !start;
  assign mismatch_s = cmp_live_s && (mem_q != exp_r[READ_LAT-1]);

  // Next-state logic; start overrides everything, including a simultaneous stop.
  always_comb begin
    state_nxt_s = state_r;
    if (start) begin
      state_nxt_s = RUN;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        RUN:     state_nxt_s = stop ? DRAIN : RUN;
        DRAIN:   state_nxt_s = pending_s ? DRAIN : DONE;
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register with registered busy/done decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Latency-matching pipeline of {valid, expected, address}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        exp_r[i]  <= '0;
        addr_r[i] <= '0;
      end
    end else begin
      exp_r[0]  <= exp_data;
      addr_r[0] <= rd_addr;
      for (int i = 1; i < READ_LAT; i++) begin
        exp_r[i]  <= exp_r[i-1];
        addr_r[i] <= addr_r[i-1];
      end
      if (start) begin
        vld_r <= '0;
      end else begin
        vld_r[0] <= cmp_en && (state_r == RUN);
        for (int i = 1; i < READ_LAT; i++) begin
          vld_r[i] <= vld_r[i-1];
        end
      end
    end
  end

  // Result registers: cleared by start, updated on every live compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_r       <= 1'b0;
      err_r        <= 1'b0;
      cnt_r        <= '0;
      first_addr_r <= '0;
      first_exp_r  <= '0;
      first_got_r  <= '0;
    end else if (start) begin
      fail_r       <= 1'b0;
      err_r        <= 1'b0;
      cnt_r        <= '0;
      first_addr_r <= '0;
      first_exp_r  <= '0;
      first_got_r  <= '0;
    end else begin
      err_r <= mismatch_s;
      if (mismatch_s) begin
        fail_r <= 1'b1;
        if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end else begin
          cnt_r <= cnt_r;
        end
        if (!fail_r) begin
          first_addr_r <= addr_r[READ_LAT-1];
          first_exp_r  <= exp_r[READ_LAT-1];
          first_got_r  <= mem_q;
        end else begin
          first_addr_r <= first_addr_r;
        end
      end else begin
        fail_r <= fail_r;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign fail       = fail_r;
  assign err_pulse  = err_r;
  assign fail_cnt   = cnt_r;
  assign first_addr = first_addr_r;
  assign first_exp  = first_exp_r;
  assign first_got  = first_got_r;

endmodule

// File: tb/tb_pmbist_resp_checker.sv
// Directed bench: four checker instances (latency 1/2/3 and a 2-bit counter) share
// the controller stimulus; a latency-delayed memory model supplies mem_q to each.
module tb_pmbist_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, stop, cmp_en;
  logic [7:0] exp_data, rd_addr;

  logic       busy [4], done [4], fail [4], errp [4];
  logic [7:0] cnt [4], faddr [4], fexp [4], fgot [4], mq [4];
  logic [1:0] cnt_c2;

  bit   [7:0] mem [256];
  logic [7:0] d0, d1, d2;

  int   n_chk = 0;
  int   n_err = 0;
  logic [3:0] err_acc;

  always #5 clk = ~clk;

  // Memory model: read data appears 1, 2 or 3 edges after the address is presented.
  always @(posedge clk) begin
    d0 <= rd_addr;
    d1 <= d0;
    d2 <= d1;
  end
  assign mq[0] = mem[d0];
  assign mq[1] = mem[d1];
  assign mq[2] = mem[d2];
  assign mq[3] = mem[d0];
  assign cnt[3] = {6'd0, cnt_c2};

  pmbist_resp_checker #(.DW(8), .AW(8), .READ_LAT(1), .CNT_W(8)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cmp_en(cmp_en),
    .exp_data(exp_data), .rd_addr(rd_addr), .mem_q(mq[0]),
    .busy(busy[0]), .done(done[0]), .fail(fail[0]), .err_pulse(errp[0]),
    .fail_cnt(cnt[0]), .first_addr(faddr[0]), .first_exp(fexp[0]), .first_got(fgot[0]));

  pmbist_resp_checker #(.DW(8), .AW(8), .READ_LAT(2), .CNT_W(8)) u_l2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cmp_en(cmp_en),
    .exp_data(exp_data), .rd_addr(rd_addr), .mem_q(mq[1]),
    .busy(busy[1]), .done(done[1]), .fail(fail[1]), .err_pulse(errp[1]),
    .fail_cnt(cnt[1]), .first_addr(faddr[1]), .first_exp(fexp[1]), .first_got(fgot[1]));

  pmbist_resp_checker #(.DW(8), .AW(8), .READ_LAT(3), .CNT_W(8)) u_l3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cmp_en(cmp_en),
    .exp_data(exp_data), .rd_addr(rd_addr), .mem_q(mq[2]),
    .busy(busy[2]), .done(done[2]), .fail(fail[2]), .err_pulse(errp[2]),
    .fail_cnt(cnt[2]), .first_addr(faddr[2]), .first_exp(fexp[2]), .first_got(fgot[2]));

  pmbist_resp_checker #(.DW(8), .AW(8), .READ_LAT(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cmp_en(cmp_en),
    .exp_data(exp_data), .rd_addr(rd_addr), .mem_q(mq[3]),
    .busy(busy[3]), .done(done[3]), .fail(fail[3]), .err_pulse(errp[3]),
    .fail_cnt(cnt_c2), .first_addr(faddr[3]), .first_exp(fexp[3]), .first_got(fgot[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) err_acc[i] = err_acc[i] | errp[i];
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    cmp_en = 1'b1; rd_addr = a; exp_data = e;
    tick();
    cmp_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic fin();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cmp_en = 1'b0;
    exp_data = 8'h00; rd_addr = 8'h00; err_acc = 4'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = 8'h55;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hA8;
    mem[8'h05] = 8'h01; mem[8'h09] = 8'h02;
    for (int i = 8'h20; i <= 8'h24; i++) mem[i] = 8'hFF;
    mem[8'h30] = 8'h3C; mem[8'h31] = 8'h77; mem[8'h32] = 8'hEE;
    mem[8'h40] = 8'h99; mem[8'h41] = 8'h99;

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_cnt",  32'(cnt[i]),  32'd0);
    end
    rst = 1'b0;

    // Test 1: four matching reads, READ_LAT=1 done timing.
    err_acc = 4'h0;
    go();
    for (int i = 0; i < 4; i++) check("t1_busy", 32'(busy[i]), 32'd1);
    for (int a = 0; a < 4; a++) rd(8'(a), 8'h55);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t1_drain_busy", 32'(busy[0]), 32'd1);
    check("t1_drain_done", 32'(done[0]), 32'd0);
    tick();
    check("t1_done", 32'(done[0]), 32'd1);
    check("t1_idle_busy", 32'(busy[0]), 32'd0);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_done_all", 32'(done[i]), 32'd1);
      check("t1_fail", 32'(fail[i]), 32'd0);
      check("t1_cnt",  32'(cnt[i]),  32'd0);
    end
    check("t1_no_err", 32'(err_acc), 32'd0);

    // Test 2: second read mismatches; err_pulse timing per latency.
    go();
    rd(8'h10, 8'hAA);
    rd(8'h11, 8'hAA);
    check("t2_l2_err_k", 32'(errp[1]), 32'd0);
    tick();
    check("t2_l1_err_k1", 32'(errp[0]), 32'd1);
    check("t2_l2_err_k1", 32'(errp[1]), 32'd0);
    tick();
    check("t2_l2_err_k2", 32'(errp[1]), 32'd1);
    check("t2_l1_err_k2", 32'(errp[0]), 32'd0);
    check("t2_fail",  32'(fail[1]),  32'd1);
    check("t2_cnt",   32'(cnt[1]),   32'd1);
    check("t2_faddr", 32'(faddr[1]), 32'h11);
    check("t2_fexp",  32'(fexp[1]),  32'hAA);
    check("t2_fgot",  32'(fgot[1]),  32'hA8);
    tick();
    check("t2_l2_err_k3", 32'(errp[1]), 32'd0);
    fin();
    check("t2_l3_done", 32'(done[2]), 32'd1);

    // Test 3: two mismatches; first_* keeps the earlier one.
    go();
    rd(8'h05, 8'h00);
    rd(8'h09, 8'h00);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_cnt",   32'(cnt[i]),   32'd2);
      check("t3_faddr", 32'(faddr[i]), 32'h05);
      check("t3_fexp",  32'(fexp[i]),  32'h00);
      check("t3_fgot",  32'(fgot[i]),  32'h01);
      check("t3_fail",  32'(fail[i]),  32'd1);
    end
    fin();

    // Test 4: five consecutive mismatches; 2-bit counter saturates.
    go();
    for (int a = 8'h20; a <= 8'h24; a++) rd(8'(a), 8'h00);
    repeat (4) tick();
    check("t4_sat_cnt",  32'(cnt[3]),   32'd3);
    check("t4_sat_fail", 32'(fail[3]),  32'd1);
    check("t4_sat_addr", 32'(faddr[3]), 32'h20);
    check("t4_wide_cnt", 32'(cnt[0]),   32'd5);
    fin();

    // Test 5: READ_LAT=3 drain with stop right after the last read; cmp_en in DRAIN ignored.
    go();
    rd(8'h30, 8'h3C);
    rd(8'h31, 8'h3C);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t5_busy_k1", 32'(busy[2]), 32'd1);
    cmp_en = 1'b1; rd_addr = 8'h32; exp_data = 8'h00;
    tick();
    cmp_en = 1'b0;
    check("t5_busy_k2", 32'(busy[2]), 32'd1);
    check("t5_done_k2", 32'(done[2]), 32'd0);
    tick();
    check("t5_done_k3", 32'(done[2]), 32'd1);
    check("t5_busy_k3", 32'(busy[2]), 32'd0);
    check("t5_err_k3",  32'(errp[2]), 32'd1);
    check("t5_cnt",     32'(cnt[2]),  32'd1);
    check("t5_faddr",   32'(faddr[2]), 32'h31);
    check("t5_fgot",    32'(fgot[2]), 32'h77);
    tick();
    check("t5_err_k4", 32'(errp[2]), 32'd0);
    repeat (3) tick();
    check("t5_cnt_hold", 32'(cnt[2]),  32'd1);
    check("t5_done_hold", 32'(done[2]), 32'd1);
    check("t5_l1_cnt",   32'(cnt[0]),  32'd1);

    // Test 6: restart mid-RUN discards an in-flight mismatch.
    go();
    err_acc = 4'h0;
    rd(8'h40, 8'h00);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      check("t6_fail", 32'(fail[i]), 32'd0);
      check("t6_cnt",  32'(cnt[i]),  32'd0);
      check("t6_busy", 32'(busy[i]), 32'd1);
    end
    check("t6_no_err", 32'(err_acc), 32'd0);

    // Asynchronous reset mid-RUN clears results before the next edge.
    rd(8'h41, 8'h00);
    repeat (4) tick();
    check("t6_pre_fail", 32'(fail[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("arst_busy",  32'(busy[i]),  32'd0);
      check("arst_fail",  32'(fail[i]),  32'd0);
      check("arst_cnt",   32'(cnt[i]),   32'd0);
      check("arst_faddr", 32'(faddr[i]), 32'd0);
      check("arst_fgot",  32'(fgot[i]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
